// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO register pair and its iterative divider.
//   div_state_e : divider FSM encodings (idle, stepping, sign fixup)
package hilo_div_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
//   rem_i/quot_i : current partial remainder and dividend/quotient shift register
//   divisor_i    : divisor magnitude
//   rem_o/quot_o : values after shifting left one bit and trial-subtracting
module restoring_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  // Two guard bits: the shifted remainder can need WIDTH+1 bits, and the top
  // bit must stay a clean sign even when the divisor is zero.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {1'b0, rem_i, quot_i[WIDTH-1]};
    trial   = shifted - {2'b00, divisor_i};
    if (!trial[WIDTH+1]) begin
      rem_o  = trial[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = shifted[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Architectural HI/LO register pair with an iterative DIV/DIVU engine.
//   Clk, Rst        : clock, synchronous active-low reset
//   ExHiLoWr/In     : ALU {HI,LO} commit (suppressed by ExStall)
//   ExStall         : blocks ALU commits and divide starts
//   DivStart/Signed : start DIV (signed) or DIVU on DivA / DivB
//   ALUhi/ALUlo     : registered HI/LO back to the ALU
//   Busy            : divide in flight
//   DivDone         : one-cycle pulse, first cycle the quotient/remainder are visible
//
// state  | meaning
// S_IDLE | no divide running; ALU commits and starts accepted
// S_DIV  | one restoring step per cycle, WIDTH steps
// S_FIX  | apply signs, write LO=quotient HI=remainder, pulse DivDone
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_HI = '0,
  parameter logic [WIDTH-1:0] RESET_LO = '0
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               ExHiLoWr,
  input  logic               ExStall,
  input  logic [2*WIDTH-1:0] ExHiLoIn,
  input  logic               DivStart,
  input  logic               DivSigned,
  input  logic [WIDTH-1:0]   DivA,
  input  logic [WIDTH-1:0]   DivB,
  output logic [WIDTH-1:0]   ALUhi,
  output logic [WIDTH-1:0]   ALUlo,
  output logic               Busy,
  output logic               DivDone
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem, step_quot;
  logic             alu_wr;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  assign alu_wr = ExHiLoWr & ~ExStall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (DivStart && !ExStall) begin
          rem_d   = '0;
          quot_d  = (DivSigned && DivA[WIDTH-1]) ? -DivA : DivA;
          dvsr_d  = (DivSigned && DivB[WIDTH-1]) ? -DivB : DivB;
          // A zero divisor must leave LO all-ones, so never flip its sign.
          q_neg_d = DivSigned & (DivA[WIDTH-1] ^ DivB[WIDTH-1]) & (|DivB);
          r_neg_d = DivSigned & DivA[WIDTH-1];
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        if (cnt_q == LAST_CNT) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        lo_d    = q_neg_q ? -quot_q : quot_q;
        hi_d    = r_neg_q ? -rem_q  : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An ALU commit always wins: it cancels a start in the same cycle and
    // aborts any divide in flight, since it is later in program order.
    if (alu_wr) begin
      hi_d    = ExHiLoIn[2*WIDTH-1:WIDTH];
      lo_d    = ExHiLoIn[WIDTH-1:0];
      done_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= RESET_HI;
      lo_q    <= RESET_LO;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      done_q  <= done_d;
    end
  end

  assign ALUhi   = hi_q;
  assign ALUlo   = lo_q;
  assign Busy    = (state_q != S_IDLE);
  assign DivDone = done_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
module tb_hilo_div_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ExHiLoWr;
  logic        ExStall;
  logic [63:0] ExHiLoIn;
  logic        DivStart;
  logic        DivSigned;
  logic [31:0] DivA;
  logic [31:0] DivB;
  logic [31:0] ALUhi;
  logic [31:0] ALUlo;
  logic        Busy;
  logic        DivDone;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  hilo_div_unit dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .ExHiLoWr  (ExHiLoWr),
    .ExStall   (ExStall),
    .ExHiLoIn  (ExHiLoIn),
    .DivStart  (DivStart),
    .DivSigned (DivSigned),
    .DivA      (DivA),
    .DivB      (DivB),
    .ALUhi     (ALUhi),
    .ALUlo     (ALUlo),
    .Busy      (Busy),
    .DivDone   (DivDone)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one divide. restart_at: cycle index at which a second DivStart is
  // pulsed (must be ignored). stall_at: cycle index with a stalled ALU write
  // (must be suppressed while the divide carries on). -1 disables either.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int restart_at,
                         input int stall_at);
    int busy_cnt;
    logic seen;
    logic [31:0] old_hi, old_lo;
    busy_cnt = 0;
    seen = 1'b0;
    old_hi = ALUhi;
    old_lo = ALUlo;
    DivStart = 1'b1; DivSigned = sgn; DivA = a; DivB = b;
    @(negedge Clk);
    DivStart = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (DivDone) begin
        seen = 1'b1;
        break;
      end
      if (Busy) busy_cnt++;
      if (ALUhi !== old_hi || ALUlo !== old_lo) begin
        chk({tag, "_early_update"}, {ALUhi, ALUlo}, {old_hi, old_lo});
        old_hi = ALUhi;
        old_lo = ALUlo;
      end
      DivStart = (i == restart_at);
      if (i == restart_at) begin DivA = 32'd50; DivB = 32'd5; DivSigned = 1'b0; end
      ExStall  = (i == stall_at);
      ExHiLoWr = (i == stall_at);
      ExHiLoIn = 64'hDEAD_BEEF_CAFE_F00D;
      @(negedge Clk);
      DivStart = 1'b0; ExStall = 1'b0; ExHiLoWr = 1'b0;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, "_hi"}, 64'(ALUhi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(ALUlo), 64'(exp_lo));
    chk({tag, "_busy_at_done"}, 64'(Busy), 64'd0);
    @(negedge Clk);
    chk({tag, "_done_pulse"}, 64'(DivDone), 64'd0);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (DivDone) pulses++;
    end
    chk({tag, "_no_done"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    Rst = 1'b0; ExHiLoWr = 1'b1; ExStall = 1'b0;
    ExHiLoIn = 64'h1111_2222_3333_4444;
    DivStart = 1'b0; DivSigned = 1'b0; DivA = '0; DivB = '0;

    // reset holds even with an ALU write pending
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_hi", 64'(ALUhi), 64'd0);
    chk("rst_lo", 64'(ALUlo), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(DivDone), 64'd0);

    // ALU commit, then stalled commit
    Rst = 1'b1; ExHiLoIn = 64'h0000_0001_FFFF_FFFE;
    @(negedge Clk);
    chk("alu_wr", {ALUhi, ALUlo}, 64'h0000_0001_FFFF_FFFE);
    ExStall = 1'b1; ExHiLoIn = 64'h0123_4567_89AB_CDEF;
    @(negedge Clk);
    chk("alu_stall", {ALUhi, ALUlo}, 64'h0000_0001_FFFF_FFFE);
    ExStall = 1'b0; ExHiLoIn = 64'h0000_0002_0000_0003;
    @(negedge Clk);
    chk("alu_wr2", {ALUhi, ALUlo}, 64'h0000_0002_0000_0003);
    ExHiLoWr = 1'b0;

    // divides
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, -1, -1);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, -1);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, -1, -1);
    run_div("divu_by0", 1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, -1, -1);
    run_div("div_neg_by0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, -1, -1);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1, -1);
    run_div("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, -1, -1);
    run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, -1, -1);
    run_div("div_restart", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 5, -1);
    run_div("div_stall", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, -1, 12);

    // abort by ALU write at cycle 10 of a divide
    DivStart = 1'b1; DivSigned = 1'b0; DivA = 32'd100; DivB = 32'd7;
    @(negedge Clk);
    DivStart = 1'b0;
    repeat (9) @(negedge Clk);
    chk("abort_busy_before", 64'(Busy), 64'd1);
    ExHiLoWr = 1'b1; ExHiLoIn = 64'hAAAA_AAAA_5555_5555;
    @(negedge Clk);
    ExHiLoWr = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(DivDone), 64'd0);
    chk("abort_hilo", {ALUhi, ALUlo}, 64'hAAAA_AAAA_5555_5555);
    count_done("abort", 40);
    chk("abort_hilo_kept", {ALUhi, ALUlo}, 64'hAAAA_AAAA_5555_5555);

    // ALU write and DivStart together in idle: write wins, no divide
    ExHiLoWr = 1'b1; ExHiLoIn = 64'h1234_5678_9ABC_DEF0;
    DivStart = 1'b1; DivA = 32'd9; DivB = 32'd3;
    @(negedge Clk);
    ExHiLoWr = 1'b0; DivStart = 1'b0;
    chk("both_busy", 64'(Busy), 64'd0);
    chk("both_hilo", {ALUhi, ALUlo}, 64'h1234_5678_9ABC_DEF0);
    count_done("both", 40);

    // reset mid-divide
    DivStart = 1'b1; DivA = 32'd100; DivB = 32'd7;
    @(negedge Clk);
    DivStart = 1'b0;
    repeat (5) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    chk("midrst_hilo", {ALUhi, ALUlo}, 64'd0);
    chk("midrst_busy", 64'(Busy), 64'd0);
    count_done("midrst", 40);
    chk("midrst_hilo_kept", {ALUhi, ALUlo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
